dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates one single-port, synchronous-read data RAM between two requesters: the CPU load/store port and the video scanout fetch port of the Game-of-Life display. It grants one access per cycle, drives the RAM control lines, and returns registered read data to the owner with a fixed latency. A starvation guard keeps video fetches moving under sustained CPU traffic. Out-of-range and misaligned CPU accesses are rejected with an error pulse.

## Interface
- AW, 9, RAM word-address width (RAM depth 2^AW words)
- MAX_WAIT, 4, cycles a pending video request may be refused before it takes priority (1..15)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; req, we, addr, wdata held stable until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_gnt  out  1  combinational grant, same cycle as the accepted request
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata holds new read data
- cpu_rdata  out  32  registered read data, held until the next CPU return
- cpu_err  out  1  one-cycle pulse: rejected access
- vid_req  in  1  video fetch request (read only), held until vid_gnt
- vid_addr  in  AW+2  byte address, word-aligned (bits [1:0] ignored)
- vid_gnt  out  1  combinational grant
- vid_rvalid  out  1  one-cycle pulse: vid_rdata holds new data
- vid_rdata  out  32  registered read data, held until the next video return
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable, qualified by mem_en
- mem_addr  out  AW  RAM word address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data, valid the cycle after a read strobe

## Operation
- At most one grant per cycle; a grant always consumes that cycle's RAM slot.
- starve = (wait_cnt == MAX_WAIT).
- cpu_gnt = cpu_req & ~(vid_req & starve); vid_gnt = vid_req & ~cpu_gnt.
- wait_cnt: cleared when vid_req is low or vid_gnt is high; otherwise incremented, saturating at MAX_WAIT.
- CPU range check: accept only if cpu_addr[31:AW+2] == 0 and cpu_addr[1:0] == 0. A rejected access is still granted, so the requester releases. mem_en stays low, and cpu_err pulses on the return cycle. cpu_rvalid does not assert and cpu_rdata is unchanged. This applies to both reads and writes.
- Granted valid CPU access: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr[AW+1:2], mem_wdata=cpu_wdata.
- Granted video access: mem_en=1, mem_we=0, mem_addr=vid_addr[AW+1:2], mem_wdata=0.
- No grant: mem_en=0, mem_we=0; mem_addr and mem_wdata are don't-care (drive 0).
- Return pipeline, per requester:
  - stage-1 register records a read tag (owner plus error flag);
  - stage 2 captures mem_rdata into the owner's rdata register and pulses rvalid, or pulses cpu_err.
- Writes produce no return pulse.

## Timing
- Grant in cycle N → mem strobe in cycle N → mem_rdata in N+1 → rdata/rvalid (or cpu_err) registered, visible in N+2.
- Back-to-back grants every cycle are supported: the pipeline holds one tag per stage, and there are no bubbles.
- Both requesters active with starve=0: CPU wins. Once video has been refused MAX_WAIT consecutive cycles, it wins the next cycle and wait_cnt clears.
- Reset (asynchronous, any time, including mid-pipeline):
  - wait_cnt=0, tags cleared;
  - cpu_rvalid=0, vid_rvalid=0, cpu_err=0;
  - cpu_rdata=0, vid_rdata=0.
  - The grant and mem outputs follow inputs combinationally. In-flight reads are dropped; no return pulse follows reset.

## Configuration
- DMEM_ARB_STARVE_EN defined: starvation guard active, as described above.
- Not defined:
  - wait_cnt is not implemented and starve is tied to 0;
  - the CPU has strict fixed priority;
  - MAX_WAIT is unused.
- The rest of the behaviour is identical.

## Test plan
- Single CPU read, addr 0x10, RAM[4]=0xDEADBEEF:
  - cpu_gnt in cycle N, with mem_addr=4 and mem_en=1;
  - cpu_rvalid pulse with cpu_rdata=0xDEADBEEF at N+2.
- CPU write addr 0x20, data 0x12345678, then CPU read 0x20 next cycle: mem_we=1 in N, and the read returns 0x12345678 at N+3 with no write-return pulse.
- Sustained cpu_req with vid_req high, MAX_WAIT=4, STARVE_EN defined:
  - vid_gnt in the 5th contended cycle, with cpu_gnt low that cycle;
  - the pattern repeats every 5 cycles.
  - Without the macro, vid_gnt never asserts.
- CPU read at 0x800 (out of range for AW=9) and at 0x6 (misaligned): cpu_gnt=1, mem_en=0, cpu_err pulse at N+2, cpu_rvalid=0, and cpu_rdata unchanged.
- Alternating CPU/video grants on consecutive cycles: each rvalid goes only to its owner at N+2, and rdata values do not cross.
- Assert rst_n low between grant and return: no rvalid or err after release, rdata=0, wait_cnt restarts from 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port, synchronous-read data RAM between the
// CPU load/store port and the video scanout fetch port.
// - One grant per cycle. The CPU has priority.
// - When DMEM_ARB_STARVE_EN is defined, a starvation guard promotes a video
//   request after MAX_WAIT consecutive refusals.
// - Read data returns through a two-stage tag pipeline, two cycles after the
//   grant.
// - A CPU access that is out of range or misaligned is granted but never
//   reaches the RAM. It returns a cpu_err pulse instead of data.
module dmem_arbiter #(
  parameter int unsigned AW       = 9,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_err,
  input  logic          vid_req,
  input  logic [AW+1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_rvalid,
  output logic [31:0]   vid_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  logic starve_s;
  logic cpu_ok_s;
  logic cpu_gnt_s;
  logic vid_gnt_s;

  // Stage-1 read tags (owner plus error flag) and stage-2 return registers
  logic        s1_cpu_rd_q, s1_cpu_rd_d;
  logic        s1_cpu_err_q, s1_cpu_err_d;
  logic        s1_vid_rd_q, s1_vid_rd_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        cpu_err_q, cpu_err_d;
  logic        vid_rvalid_q, vid_rvalid_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] vid_rdata_q, vid_rdata_d;

  // The byte-lane bits of the video address carry no information
  logic unused_s;
  assign unused_s = ^vid_addr[1:0];

  // A CPU access is legal only if it is word aligned and inside the RAM
  assign cpu_ok_s  = (cpu_addr[31:AW+2] == {(30-AW){1'b0}}) && (cpu_addr[1:0] == 2'b00);
  assign cpu_gnt_s = cpu_req & ~(vid_req & starve_s);
  assign vid_gnt_s = vid_req & ~cpu_gnt_s;
  assign cpu_gnt   = cpu_gnt_s;
  assign vid_gnt   = vid_gnt_s;

`ifdef DMEM_ARB_STARVE_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;

  // Count consecutive refusals of a pending video request, saturating at MAX_WAIT
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!vid_req || vid_gnt_s) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Refusal counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign starve_s = (wait_cnt_q == 4'(MAX_WAIT));
`else
  // Without the guard the CPU has strict priority and MAX_WAIT has no effect
  logic unused_cfg_s;
  assign unused_cfg_s = ^(4'(MAX_WAIT));
  assign starve_s     = 1'b0;
`endif

  // Drive the RAM control lines from whichever requester holds this cycle's slot
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {AW{1'b0}};
    mem_wdata = 32'd0;
    if (cpu_gnt_s) begin
      if (cpu_ok_s) begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr[AW+1:2];
        mem_wdata = cpu_wdata;
      end else begin
        mem_en = 1'b0;
      end
    end else if (vid_gnt_s) begin
      mem_en   = 1'b1;
      mem_addr = vid_addr[AW+1:2];
    end else begin
      mem_en = 1'b0;
    end
  end

  // Next-state logic of the return pipeline: tag in stage 1, capture in stage 2
  always_comb begin
    s1_cpu_rd_d  = cpu_gnt_s & cpu_ok_s & ~cpu_we;
    s1_cpu_err_d = cpu_gnt_s & ~cpu_ok_s;
    s1_vid_rd_d  = vid_gnt_s;
    cpu_rvalid_d = s1_cpu_rd_q;
    cpu_err_d    = s1_cpu_err_q;
    vid_rvalid_d = s1_vid_rd_q;
    cpu_rdata_d  = cpu_rdata_q;
    vid_rdata_d  = vid_rdata_q;
    if (s1_cpu_rd_q) begin
      cpu_rdata_d = mem_rdata;
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
    if (s1_vid_rd_q) begin
      vid_rdata_d = mem_rdata;
    end else begin
      vid_rdata_d = vid_rdata_q;
    end
  end

  // Return pipeline registers; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_cpu_rd_q  <= 1'b0;
      s1_cpu_err_q <= 1'b0;
      s1_vid_rd_q  <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      cpu_err_q    <= 1'b0;
      vid_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      vid_rdata_q  <= 32'd0;
    end else begin
      s1_cpu_rd_q  <= s1_cpu_rd_d;
      s1_cpu_err_q <= s1_cpu_err_d;
      s1_vid_rd_q  <= s1_vid_rd_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_err_q    <= cpu_err_d;
      vid_rvalid_q <= vid_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      vid_rdata_q  <= vid_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign vid_rvalid = vid_rvalid_q;
  assign vid_rdata  = vid_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (AW=9, MAX_WAIT=4) with a return scoreboard.
// The bench keeps a shadow copy of the RAM contents and uses it to form the
// expected read data.
module tb_dmem_arbiter;
  localparam int AW = 9;

`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif

  typedef struct {
    int          due;
    bit          vid;
    bit          err;
    logic [31:0] data;
  } ret_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]   cpu_addr = 32'd0, cpu_wdata = 32'd0;
  logic          cpu_gnt, cpu_rvalid, cpu_err;
  logic [31:0]   cpu_rdata;
  logic          vid_req = 1'b0;
  logic [AW+1:0] vid_addr = '0;
  logic          vid_gnt, vid_rvalid;
  logic [31:0]   vid_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [31:0] shadow [0:(1<<AW)-1];
  ret_t        sb_q[$];
  logic [31:0] exp_cdata = 32'd0;
  logic [31:0] exp_vdata = 32'd0;
  int          cyc_n = 0;
  int          tests = 0;
  int          fails = 0;

  dmem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Drive one cycle, check its grants/strobe and any return due, push new returns
  task automatic cyc(input logic creq, input logic cwe, input logic [31:0] caddr,
                     input logic [31:0] cwd, input logic vreq, input logic [10:0] vaddr,
                     input logic exp_cg, input logic exp_vg);
    ret_t r;
    logic ok;
    logic e_crv, e_cerr, e_vrv;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    vid_req = vreq; vid_addr = vaddr;
    @(negedge clk);
    e_crv = 1'b0; e_cerr = 1'b0; e_vrv = 1'b0;
    if (sb_q.size() > 0 && sb_q[0].due == cyc_n) begin
      r = sb_q.pop_front();
      if (r.vid)      begin e_vrv = 1'b1; exp_vdata = r.data; end
      else if (r.err) e_cerr = 1'b1;
      else            begin e_crv = 1'b1; exp_cdata = r.data; end
    end
    chk("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, e_crv});
    chk("cpu_err",    {31'd0, cpu_err},    {31'd0, e_cerr});
    chk("vid_rvalid", {31'd0, vid_rvalid}, {31'd0, e_vrv});
    chk("cpu_rdata",  cpu_rdata, exp_cdata);
    chk("vid_rdata",  vid_rdata, exp_vdata);
    chk("cpu_gnt",    {31'd0, cpu_gnt}, {31'd0, exp_cg});
    chk("vid_gnt",    {31'd0, vid_gnt}, {31'd0, exp_vg});
    ok = (caddr[31:11] == 21'd0) && (caddr[1:0] == 2'b00);
    if (exp_cg) begin
      chk("mem_en_cpu", {31'd0, mem_en}, {31'd0, ok});
      if (ok) begin
        chk("mem_we_cpu",   {31'd0, mem_we},   {31'd0, cwe});
        chk("mem_addr_cpu", {23'd0, mem_addr}, {23'd0, caddr[10:2]});
        if (cwe) begin
          chk("mem_wdata", mem_wdata, cwd);
          shadow[caddr[10:2]] = cwd;
        end else begin
          sb_q.push_back('{cyc_n + 2, 1'b0, 1'b0, shadow[caddr[10:2]]});
        end
      end else begin
        sb_q.push_back('{cyc_n + 2, 1'b0, 1'b1, 32'd0});
      end
    end else if (exp_vg) begin
      chk("mem_en_vid",   {31'd0, mem_en},   32'd1);
      chk("mem_we_vid",   {31'd0, mem_we},   32'd0);
      chk("mem_addr_vid", {23'd0, mem_addr}, {23'd0, vaddr[10:2]});
      sb_q.push_back('{cyc_n + 2, 1'b1, 1'b0, shadow[vaddr[10:2]]});
    end else begin
      chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
      chk("mem_we_idle", {31'd0, mem_we}, 32'd0);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 11'd0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state();
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_cpu_err",    {31'd0, cpu_err},    32'd0);
    chk("rst_vid_rvalid", {31'd0, vid_rvalid}, 32'd0);
    chk("rst_cpu_rdata",  cpu_rdata, 32'd0);
    chk("rst_vid_rdata",  vid_rdata, 32'd0);
  endtask

  initial begin
    logic vg;
    for (int k = 0; k < (1 << AW); k++) begin
      ram[k]    = {16'hA5A5, 7'd0, k[8:0]};
      shadow[k] = {16'hA5A5, 7'd0, k[8:0]};
    end
    ram[4]    = 32'hDEADBEEF;
    shadow[4] = 32'hDEADBEEF;

    #2;
    chk_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single CPU read of 0x10 (word 4)
    cyc(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 11'd0, 1'b1, 1'b0);
    idle(2);

    // Write 0x20 then read it back on the very next cycle
    cyc(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 11'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h20, 32'd0,        1'b0, 11'd0, 1'b1, 1'b0);
    idle(3);

    // Out-of-range and misaligned accesses
    cyc(1'b1, 1'b0, 32'h800, 32'd0,        1'b0, 11'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h6,   32'd0,        1'b0, 11'd0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 32'h6,   32'hFFFFFFFF, 1'b0, 11'd0, 1'b1, 1'b0);
    idle(3);

    // Alternating owners with no bubbles, including one contended cycle
    cyc(1'b1, 1'b0, 32'h24, 32'd0, 1'b0, 11'h000, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 11'h030, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h28, 32'd0, 1'b0, 11'h000, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 11'h034, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 11'h03B, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 32'h0,  32'd0, 1'b1, 11'h03B, 1'b0, 1'b1);
    idle(3);

    // Sustained contention: video wins every 5th cycle only with the guard
    for (int i = 0; i < 10; i++) begin
      vg = STARVE && (i % 5 == 4);
      cyc(1'b1, 1'b0, 32'h2C, 32'd0, 1'b1, 11'h044, !vg, vg);
    end
    idle(3);

    // Reset with reads in flight, then confirm the refusal count restarts
    cyc(1'b1, 1'b0, 32'h10, 32'd0, 1'b1, 11'h048, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h24, 32'd0, 1'b1, 11'h048, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk_reset_state();
    sb_q.delete();
    exp_cdata = 32'd0;
    exp_vdata = 32'd0;
    @(posedge clk); #1;
    cyc_n++;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vg = STARVE && (i == 4);
      cyc(1'b1, 1'b0, 32'h28, 32'd0, 1'b1, 11'h048, !vg, vg);
    end
    idle(3);
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
